// File: rtl/schoolbook_radix.sv
// schoolbook_radix: sequential radix-2^D schoolbook multiplier.
//
// Produces c = a * b (exact 2N-bit product) by scanning the multiplier b
// one D-bit digit per clock, least significant digit first, and adding
// a * digit, shifted into place, to a 2N-bit accumulator.
// K = ceil(N/D) iterations per product.
//
// Parameters:
//   N : operand width in bits (N >= 2)
//   D : multiplier digit width per cycle (1 <= D <= N)
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   start : request a multiplication, sampled only while idle
//   a, b  : N-bit operands, latched on the accepting edge
//   busy  : high while an operation is in progress
//   done  : one-cycle pulse when c holds a new product
//   c     : registered 2N-bit product, stable between completions
//
// Optional feature (compile-time macro SCHOOLBOOK_EARLY_EXIT_EN):
//   when defined, RUN ends at the first iteration after which every
//   remaining digit of the latched multiplier is zero.
module schoolbook_radix #(
  parameter int N = 283,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int K  = (N + D - 1) / D;
  localparam int CW = $clog2(K + 1);
  // Multiplier is stored zero-extended to a whole number of digits so the
  // final, partial digit reads zeros in its upper bits.
  localparam int BW = K * D;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [BW-1:0]  b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [31:0]    shamt;
  logic [D-1:0]   digit;
  logic [2*N-1:0] pp;
  logic           last;

  // Current digit and its shifted partial product. The partial product
  // never exceeds a*b < 2^(2N), so computing it in 2N bits is exact.
  always_comb begin
    shamt = 32'(cnt_q) * 32'(D);
    digit = D'(b_q >> shamt);
    pp    = ((2*N)'(a_q) * (2*N)'(digit)) << shamt;
  end

`ifdef SCHOOLBOOK_EARLY_EXIT_EN
  logic [BW-1:0] rest;
  always_comb begin
    // Digits above the one being added this cycle.
    rest = b_q >> (shamt + 32'(D));
    last = (cnt_q == CW'(K - 1)) || (rest == '0);
  end
`else
  always_comb begin
    last = (cnt_q == CW'(K - 1));
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = BW'(b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          c_d     = acc_q + pp;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_schoolbook_radix.sv
// Directed bench for schoolbook_radix: a default-size instance (N=283, D=4)
// and a small instance (N=8, D=3) share clock and reset.
module tb_schoolbook_radix;

  localparam int NB = 283;
  localparam int DB = 4;
  localparam int KB = 71;
  localparam int NS = 8;
  localparam int DS = 3;
  localparam int KS = 3;
`ifdef SCHOOLBOOK_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start_b, start_s;
  logic [NB-1:0]     a_b, b_b;
  logic [NS-1:0]     a_s, b_s;
  logic              busy_b, done_b, busy_s, done_s;
  logic [2*NB-1:0]   c_b;
  logic [2*NS-1:0]   c_s;

  int checks = 0;
  int errors = 0;

  schoolbook_radix u_big (
    .clk(clk), .rst(rst), .start(start_b), .a(a_b), .b(b_b),
    .busy(busy_b), .done(done_b), .c(c_b)
  );

  schoolbook_radix #(.N(NS), .D(DS)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .c(c_s)
  );

  task automatic check(input string tag, input logic [2*NB-1:0] obs, input logic [2*NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_busy(input bit sel);
    return sel ? busy_s : busy_b;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done_s : done_b;
  endfunction

  function automatic logic [2*NB-1:0] cur_c(input bit sel);
    return sel ? (2*NB)'(c_s) : c_b;
  endfunction

  // Expected cycles from accept to done: K normally, or one past the
  // highest nonzero digit (at least 1) with early exit.
  function automatic int exp_lat(input logic [NB-1:0] bv, input int d, input int k);
    logic [NB-1:0] t;
    logic [NB-1:0] mask;
    if (!EARLY) return k;
    mask = (NB'(1) << d) - NB'(1);
    for (int j = k - 1; j >= 0; j--) begin
      t = bv >> (j * d);
      if ((t & mask) != '0) return j + 1;
    end
    return 1;
  endfunction

  // Issue one request from idle (called #1 after an edge), scramble the
  // inputs after accept, then check busy, latency, product, done pulse width.
  task automatic run_op(input bit sel, input logic [NB-1:0] av, input logic [NB-1:0] bv,
                        input logic [2*NB-1:0] exp_c, input int exp_l, input string tag);
    int cyc;
    bit busy_ok;
    bit seen;
    if (sel) begin start_s = 1'b1; a_s = av[NS-1:0]; b_s = bv[NS-1:0]; end
    else     begin start_b = 1'b1; a_b = av; b_b = bv; end
    @(posedge clk); #1;
    start_s = 1'b0; start_b = 1'b0;
    a_s = ~a_s; b_s = ~b_s; a_b = ~a_b; b_b = ~b_b;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (cur_busy(sel) !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (cur_done(sel) === 1'b1) seen = 1'b1;
    end
    check({tag, "/done_seen"}, (2*NB)'(seen), (2*NB)'(1));
    check({tag, "/busy_held"}, (2*NB)'(busy_ok), (2*NB)'(1));
    check({tag, "/latency"}, (2*NB)'(cyc), (2*NB)'(exp_l));
    check({tag, "/c"}, cur_c(sel), exp_c);
    check({tag, "/busy_at_done"}, (2*NB)'(cur_busy(sel)), '0);
    @(posedge clk); #1;
    check({tag, "/done_one_cycle"}, (2*NB)'(cur_done(sel)), '0);
    check({tag, "/c_stable"}, cur_c(sel), exp_c);
  endtask

  initial begin
    logic [2*NB-1:0] one;
    logic [2*NB-1:0] exp_ones;
    logic [2*NB-1:0] exp_mul;
    int  cyc;
    bit  seen;

    rst = 1'b1; start_b = 1'b0; start_s = 1'b0;
    a_b = '0; b_b = '0; a_s = '0; b_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy_b", (2*NB)'(busy_b), '0);
    check("reset/done_b", (2*NB)'(done_b), '0);
    check("reset/c_b", c_b, '0);
    check("reset/busy_s", (2*NB)'(busy_s), '0);
    check("reset/done_s", (2*NB)'(done_s), '0);
    check("reset/c_s", (2*NB)'(c_s), '0);

    // Start presented on the first edge after reset release.
    rst = 1'b0;
    run_op(1'b0, NB'(1), NB'(1), (2*NB)'(1), exp_lat(NB'(1), DB, KB), "big_1x1");

    // All-ones operands: 2^566 - 2^284 + 1.
    one = (2*NB)'(1);
    exp_ones = one - (one << 284);
    run_op(1'b0, '1, '1, exp_ones, exp_lat('1, DB, KB), "big_ones");

    run_op(1'b1, NB'(255), NB'(255), (2*NB)'(65025), exp_lat(NB'(255), DS, KS), "small_255x255");
    run_op(1'b1, NB'(200), NB'(3), (2*NB)'(600), exp_lat(NB'(3), DS, KS), "small_200x3");

    // Second request while busy is ignored; a request in the done cycle is taken.
    start_s = 1'b1; a_s = 8'd3; b_s = 8'd4;
    @(posedge clk); #1;
    a_s = 8'd5; b_s = 8'd7;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s === 1'b1) seen = 1'b1;
    end
    check("b2b_first/done_seen", (2*NB)'(seen), (2*NB)'(1));
    check("b2b_first/latency", (2*NB)'(cyc), (2*NB)'(exp_lat(NB'(4), DS, KS)));
    check("b2b_first/c", (2*NB)'(c_s), (2*NB)'(12));
    @(posedge clk); #1;
    start_s = 1'b0;
    check("b2b_second/busy", (2*NB)'(busy_s), (2*NB)'(1));
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s === 1'b1) seen = 1'b1;
    end
    check("b2b_second/done_seen", (2*NB)'(seen), (2*NB)'(1));
    check("b2b_second/latency", (2*NB)'(cyc), (2*NB)'(exp_lat(NB'(7), DS, KS)));
    check("b2b_second/c", (2*NB)'(c_s), (2*NB)'(35));
    @(posedge clk); #1;

    run_op(1'b0, NB'(12345), NB'(0), '0, exp_lat(NB'(0), DB, KB), "big_b0");
    run_op(1'b0, NB'(12345), NB'(1), (2*NB)'(12345), exp_lat(NB'(1), DB, KB), "big_b1");

    exp_mul = (2*NB)'(64'hDEADBEEF) * (2*NB)'(64'h12345);
    run_op(1'b0, NB'(64'hDEADBEEF), NB'(64'h12345), exp_mul,
           exp_lat(NB'(64'h12345), DB, KB), "big_mix");

    // Reset during iteration 10 of an operation with a high multiplier digit.
    start_b = 1'b1; a_b = NB'(3); b_b = NB'(1) << 280;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort/c", c_b, '0);
    check("abort/busy", (2*NB)'(busy_b), '0);
    check("abort/done", (2*NB)'(done_b), '0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done_b === 1'b1) seen = 1'b1;
    end
    check("abort/no_done", (2*NB)'(seen), '0);

    run_op(1'b0, NB'(3), NB'(5), (2*NB)'(15), exp_lat(NB'(5), DB, KB), "big_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
